// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : FETCH/DECODE/EXEC/WB sequencer for addi and bne, with traps
// on illegal opcode / fetch timeout. Macro PERF_COUNTERS_EN adds counters. Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [6:0]           instr_opcode,
    input  logic                 EQ,
    input  logic                 imem_ack,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 pc_en,
    output logic                 PCsrc,
    output logic                 RegWrite,
    output logic                 ALUsrc,
    output logic [2:0]           ALUctrl,
    output logic                 ImmSrc,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
);

    localparam int          TO_W          = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [6:0]  c_OP_ADDI     = 7'b0010011;
    localparam logic [6:0]  c_OP_BNE      = 7'b1100011;
    localparam logic [1:0]  c_CAUSE_NONE  = 2'b00;
    localparam logic [1:0]  c_CAUSE_ILL   = 2'b01;
    localparam logic [1:0]  c_CAUSE_TO    = 2'b10;
    localparam logic [2:0]  c_ALU_ADD     = 3'b000;
    localparam logic [2:0]  c_ALU_SUB     = 3'b001;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC_I = 3'd2,
        WB     = 3'd3,
        EXEC_B = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_req,   w_req_nxt;
    logic [TO_W-1:0] r_to,    w_to_nxt;
    logic [1:0]      r_cause, w_cause_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FETCH;
            r_req   <= 1'b0;
            r_to    <= '0;
            r_cause <= c_CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_to    <= w_to_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // The request flag is the only FETCH sub-state: once raised it ignores run.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_to_nxt    = r_to;
        w_cause_nxt = r_cause;
        case (r_state)
            FETCH: begin
                if (r_req) begin
                    if (imem_ack) begin
                        w_req_nxt   = 1'b0;
                        w_to_nxt    = '0;
                        w_state_nxt = DECODE;
                    end else if (r_to == c_TO_LAST) begin
                        w_req_nxt   = 1'b0;
                        w_to_nxt    = '0;
                        w_cause_nxt = c_CAUSE_TO;
                        w_state_nxt = TRAP;
                    end else begin
                        w_to_nxt = r_to + TO_W'(1);
                    end
                end else if (run) begin
                    w_req_nxt = 1'b1;
                end
            end
            DECODE: begin
                if (instr_opcode == c_OP_ADDI) begin
                    w_state_nxt = EXEC_I;
                end else if (instr_opcode == c_OP_BNE) begin
                    w_state_nxt = EXEC_B;
                end else begin
                    w_cause_nxt = c_CAUSE_ILL;
                    w_state_nxt = TRAP;
                end
            end
            EXEC_I:  w_state_nxt = WB;
            WB:      w_state_nxt = FETCH;
            EXEC_B:  w_state_nxt = FETCH;
            TRAP:    w_state_nxt = TRAP;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        PCsrc      = 1'b0;
        RegWrite   = 1'b0;
        ALUsrc     = 1'b0;
        ALUctrl    = c_ALU_ADD;
        ImmSrc     = 1'b0;
        halted     = 1'b0;
        trap_cause = r_cause;
        case (r_state)
            FETCH: begin
                imem_req = r_req;
                ir_load  = r_req & imem_ack;
            end
            EXEC_I: begin
                ALUsrc = 1'b1;
            end
            WB: begin
                ALUsrc   = 1'b1;
                RegWrite = 1'b1;
                pc_en    = 1'b1;
            end
            EXEC_B: begin
                ALUctrl = c_ALU_SUB;
                ImmSrc  = 1'b1;
                pc_en   = 1'b1;
                PCsrc   = ~EQ;
            end
            TRAP: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

`ifdef PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_instret_cnt;
    logic                 w_retire;

    assign w_retire = (r_state == WB) || (r_state == EXEC_B);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != TRAP) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            end
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : table-driven and hand-sequenced bench for multicycle_ctrl
// with a retire scoreboard. Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int CW = 4;
`ifdef PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BNE  = 7'b1100011;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic [6:0]    instr_opcode = 7'd0;
    logic          EQ = 1'b0;
    logic          imem_ack = 1'b0;
    logic          imem_req, ir_load, pc_en, PCsrc, RegWrite, ALUsrc, ImmSrc, halted;
    logic [2:0]    ALUctrl;
    logic [1:0]    trap_cause;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    multicycle_ctrl #(.TIMEOUT(16), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .instr_opcode(instr_opcode), .EQ(EQ),
        .imem_ack(imem_ack), .imem_req(imem_req), .ir_load(ir_load), .pc_en(pc_en),
        .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .ImmSrc(ImmSrc), .halted(halted), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] opcode;
        logic       eq;
        int         delay;
        int         exp_lat;
        logic [1:0] exp_cause;
        logic       exp_rw;
        logic       exp_pcsrc;
    } vec_t;

    typedef struct {
        logic       rw;
        logic       pcsrc;
        logic       alusrc;
        logic [2:0] aluctrl;
        logic       immsrc;
    } ret_t;

    ret_t sb[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic ret_t model_ret(input logic [6:0] op, input logic rw, input logic pcsrc);
        ret_t r;
        r.rw      = rw;
        r.pcsrc   = pcsrc;
        r.alusrc  = (op == ADDI);
        r.aluctrl = (op == ADDI) ? 3'b000 : 3'b001;
        r.immsrc  = (op == BNE);
        return r;
    endfunction

    // Retire scoreboard plus per-cycle invariants.
    always @(negedge clk) begin
        ret_t e;
        if (rst) begin
            check("rw_without_pc_en", 32'(RegWrite & ~pc_en), 32'd0);
            check("trap_quiet", 32'(halted & (imem_req | ir_load | pc_en | RegWrite |
                                              ALUsrc | ImmSrc | (|ALUctrl))), 32'd0);
            if (pc_en) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_retire: got pc_en=1 expected no retire at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("ret_RegWrite", 32'(RegWrite), 32'(e.rw));
                    check("ret_PCsrc",    32'(PCsrc),    32'(e.pcsrc));
                    check("ret_ALUsrc",   32'(ALUsrc),   32'(e.alusrc));
                    check("ret_ALUctrl",  32'(ALUctrl),  32'(e.aluctrl));
                    check("ret_ImmSrc",   32'(ImmSrc),   32'(e.immsrc));
                end
            end
        end
    end

    task automatic do_reset(input logic run_val);
        @(posedge clk); #1;
        rst = 1'b0; run = run_val; imem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_trap_cause", 32'(trap_cause), 32'd0);
        check("rst_strobes", 32'({ir_load, pc_en, RegWrite, ALUsrc, ImmSrc, PCsrc, ALUctrl}), 32'd0);
        check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    endtask

    task automatic wait_retire(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(posedge clk); #1;
            imem_ack = 1'b0;
            @(negedge clk);
            if (pc_en) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic apply_vec(input vec_t v);
        int n = 0;
        int lat = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        run = 1'b1; instr_opcode = v.opcode; EQ = v.eq; imem_ack = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (imem_req && n == v.delay) begin
                done = 1'b1;
            end else begin
                if (imem_req) n++;
                @(negedge clk);
                @(posedge clk); #1;
            end
        end
        check("vec_ack_reached", 32'(done), 32'd1);
        imem_ack = 1'b1;
        run = 1'b0;
        if (v.exp_cause == 2'b00) sb.push_back(model_ret(v.opcode, v.exp_rw, v.exp_pcsrc));
        @(negedge clk);
        check("vec_ir_load", 32'(ir_load), 32'd1);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); #1;
            imem_ack = 1'b0;
            lat++;
            @(negedge clk);
            if (pc_en || halted) done = 1'b1;
        end
        check("vec_latency", 32'(lat), 32'(v.exp_lat));
        if (v.exp_cause != 2'b00) begin
            check("vec_halted", 32'(halted), 32'd1);
            check("vec_trap_cause", 32'(trap_cause), 32'(v.exp_cause));
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                run = 1'b1;
                imem_ack = c[0];
            end
            @(negedge clk);
            check("trap_held_halted", 32'(halted), 32'd1);
            check("trap_held_cause", 32'(trap_cause), 32'(v.exp_cause));
            do_reset(1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //              opcode      eq    dly lat cause  rw    pcsrc
        vecs[0] = '{ADDI,        1'b0,  0, 3, 2'b00, 1'b1, 1'b0};
        vecs[1] = '{ADDI,        1'b1,  3, 3, 2'b00, 1'b1, 1'b0};
        vecs[2] = '{BNE,         1'b0,  0, 2, 2'b00, 1'b0, 1'b1};
        vecs[3] = '{BNE,         1'b1,  2, 2, 2'b00, 1'b0, 1'b0};
        vecs[4] = '{ADDI,        1'b0, 14, 3, 2'b00, 1'b1, 1'b0};
        vecs[5] = '{ADDI,        1'b0, 15, 3, 2'b00, 1'b1, 1'b0};
        vecs[6] = '{BNE,         1'b0,  7, 2, 2'b00, 1'b0, 1'b1};
        vecs[7] = '{7'b0110011,  1'b0,  1, 2, 2'b01, 1'b0, 1'b0};
        vecs[8] = '{BNE,         1'b1, 15, 2, 2'b00, 1'b0, 1'b0};
        vecs[9] = '{7'b0000011,  1'b1,  0, 2, 2'b01, 1'b0, 1'b0};

        // Cycle-exact addi straight out of reset.
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b1;
        @(negedge clk);
        check("c0_imem_req", 32'(imem_req), 32'd0);
        check("c0_outputs", 32'({ir_load, pc_en, RegWrite, ALUsrc, ImmSrc, halted, trap_cause}), 32'd0);
        @(posedge clk); #1;
        imem_ack = 1'b1; instr_opcode = ADDI;
        sb.push_back(model_ret(ADDI, 1'b1, 1'b0));
        @(negedge clk);
        check("c1_ir_load", 32'(ir_load), 32'd1);
        check("c1_imem_req", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        imem_ack = 1'b0; run = 1'b0;
        @(negedge clk);
        check("c2_decode_quiet", 32'({pc_en, RegWrite, ALUsrc, ImmSrc, imem_req}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("c3_exec_i", 32'({ALUsrc, RegWrite, pc_en}), 32'b100);
        @(posedge clk); #1;
        @(negedge clk);
        check("c4_wb", 32'({RegWrite, pc_en, PCsrc}), 32'b110);
        @(posedge clk); #1;
        @(negedge clk);
        check("c5_no_strobes", 32'({RegWrite, pc_en}), 32'd0);
        check("c5_instret", 32'(instret_cnt), PERF ? 32'd1 : 32'd0);
        check("c5_cycle_cnt", 32'(cycle_cnt), PERF ? 32'd5 : 32'd0);

        for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

        // Fetch timeout: request stays up for exactly TIMEOUT cycles.
        do_reset(1'b0);
        @(posedge clk); #1;
        run = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (imem_req) n++;
            if (halted) break;
            @(posedge clk); #1;
        end
        check("timeout_req_cycles", 32'(n), 32'd16);
        check("timeout_halted", 32'(halted), 32'd1);
        check("timeout_cause", 32'(trap_cause), 32'd2);
        do_reset(1'b0);

        // Idle ack ignored; run drop during outstanding request ignored.
        @(posedge clk); #1;
        imem_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_ir_load", 32'(ir_load), 32'd0);
        @(posedge clk); #1;
        imem_ack = 1'b0; run = 1'b1;
        @(negedge clk);
        check("idle_ack_no_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("req_holds", 32'(imem_req), 32'd1);
            @(posedge clk); #1;
        end
        imem_ack = 1'b1; instr_opcode = BNE; EQ = 1'b0;
        sb.push_back(model_ret(BNE, 1'b0, 1'b1));
        @(negedge clk);
        check("late_ack_ir_load", 32'(ir_load), 32'd1);
        wait_retire("late_ack_retire");

        // Reset while a request is outstanding drops it.
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_abort_req", 32'(imem_req), 32'd1);
        do_reset(1'b1);
        run = 1'b0;

        // Counter wrap over 16 cycles of idle.
        do_reset(1'b0);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c == 8)  check("cnt_mid", 32'(cycle_cnt), PERF ? 32'd8 : 32'd0);
            if (c == 15) check("cnt_max", 32'(cycle_cnt), PERF ? 32'd15 : 32'd0);
            if (c == 16) check("cnt_wrap", 32'(cycle_cnt), 32'd0);
        end
        check("instret_after_reset", 32'(instret_cnt), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
